// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, SPI bridge)
// and the single-port RAM.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              spi_req;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_gnt;
  logic              spi_rvalid;
  logic [DATA_W-1:0] spi_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  spi_req, spi_we, spi_addr, spi_wdata,
    output spi_gnt, spi_rvalid, spi_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output spi_req, spi_we, spi_addr, spi_wdata,
    input  spi_gnt, spi_rvalid, spi_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority CPU/SPI arbiter for the shared data memory, with a starvation
// counter that force-grants SPI, and read-return steering to the issuing requester.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic [1:0] rd_tag;   // {valid, owner}; owner 1 = SPI
  logic       cpu_gnt;
  logic       spi_gnt;

  always_comb begin
    cpu_gnt = 1'b0;
    spi_gnt = 1'b0;
    if (!reset) begin
      if (bus.spi_req && (!bus.cpu_req || wait_cnt == MAX_CNT))
        spi_gnt = 1'b1;
      else if (bus.cpu_req)
        cpu_gnt = 1'b1;
    end
  end

  always_comb begin
    bus.cpu_gnt   = cpu_gnt;
    bus.spi_gnt   = spi_gnt;
    bus.mem_en    = cpu_gnt | spi_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (spi_gnt) begin
      bus.mem_we    = bus.spi_we;
      bus.mem_addr  = bus.spi_addr;
      bus.mem_wdata = bus.spi_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      rd_tag   <= '0;
    end else begin
      if (bus.spi_req && !spi_gnt) begin
        if (wait_cnt != MAX_CNT)
          wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end

      if (bus.mem_en && !bus.mem_we)
        rd_tag <= {1'b1, spi_gnt};
      else
        rd_tag <= '0;
    end
  end

  // Gating with reset also kills a return whose read was granted just before reset.
  assign bus.cpu_rvalid = rd_tag[1] & ~rd_tag[0] & ~reset;
  assign bus.spi_rvalid = rd_tag[1] &  rd_tag[0] & ~reset;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.spi_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-requester traffic plus
// hand-written contention and reset-mid-read sequences.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus ();

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural RAM with a registered read port.
  logic [15:0] ram [0:8191];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we)
      ram[bus.mem_addr] <= bus.mem_wdata;
    else if (bus.mem_en)
      bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [12:0] c_addr;
    logic [15:0] c_wd;
    logic        s_req;
    logic        s_we;
    logic [12:0] s_addr;
    logic [15:0] s_wd;
    logic        e_cgnt;
    logic        e_sgnt;
    logic        e_en;
    logic        e_we;
    logic [12:0] e_addr;
    logic [15:0] e_wd;
    logic        e_crv;
    logic        e_srv;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c_req, input logic c_we, input logic [12:0] c_addr,
                       input logic [15:0] c_wd, input logic s_req, input logic s_we,
                       input logic [12:0] s_addr, input logic [15:0] s_wd);
    bus.cpu_req   = c_req;
    bus.cpu_we    = c_we;
    bus.cpu_addr  = c_addr;
    bus.cpu_wdata = c_wd;
    bus.spi_req   = s_req;
    bus.spi_we    = s_we;
    bus.spi_addr  = s_addr;
    bus.spi_wdata = s_wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b0, 13'd0,    16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 13'd100,  16'h0002, 1'b0, 1'b0, 13'd0,    16'h0000,
                 1'b1, 1'b0, 1'b1, 1'b1, 13'd100,  16'h0002, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 13'd100,  16'h0000, 1'b0, 1'b0, 13'd0,    16'h0000,
                 1'b1, 1'b0, 1'b1, 1'b0, 13'd100,  16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b0, 13'd0,    16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 16'h0002};
    vecs[4]  = '{1'b0, 1'b0, 13'd0,    16'h0000, 1'b1, 1'b1, 13'h1FFF, 16'hBEEF,
                 1'b0, 1'b1, 1'b1, 1'b1, 13'h1FFF, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'h1FFF, 16'h0000,
                 1'b0, 1'b1, 1'b1, 1'b0, 13'h1FFF, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b0, 13'd0,    16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b1, 16'hBEEF};
    vecs[7]  = '{1'b1, 1'b1, 13'd10,   16'h1111, 1'b0, 1'b1, 13'd20,   16'h2222,
                 1'b1, 1'b0, 1'b1, 1'b1, 13'd10,   16'h1111, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 13'd10,   16'h5555, 1'b1, 1'b1, 13'd20,   16'h2222,
                 1'b0, 1'b1, 1'b1, 1'b1, 13'd20,   16'h2222, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 13'd10,   16'h0000, 1'b0, 1'b0, 13'd0,    16'h0000,
                 1'b1, 1'b0, 1'b1, 1'b0, 13'd10,   16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'd20,   16'h0000,
                 1'b0, 1'b1, 1'b1, 1'b0, 13'd20,   16'h0000, 1'b1, 1'b0, 16'h1111};
    vecs[11] = '{1'b0, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b0, 13'd0,    16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b1, 16'h2222};

    // Reset with both requests high: no grants may leak out.
    reset = 1'b1;
    drive(1'b1, 1'b1, 13'd5, 16'h0005, 1'b1, 1'b1, 13'd6, 16'h0006);
    bus.mem_rdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
      chk("rst_spi_gnt", 32'(bus.spi_gnt), 32'd0);
      chk("rst_mem_en",  32'(bus.mem_en),  32'd0);
      chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
      next_cycle();
    end
    reset = 1'b0;

    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].c_req, vecs[v].c_we, vecs[v].c_addr, vecs[v].c_wd,
            vecs[v].s_req, vecs[v].s_we, vecs[v].s_addr, vecs[v].s_wd);
      @(negedge clk);
      chk($sformatf("v%0d_cpu_gnt", v),    32'(bus.cpu_gnt),    32'(vecs[v].e_cgnt));
      chk($sformatf("v%0d_spi_gnt", v),    32'(bus.spi_gnt),    32'(vecs[v].e_sgnt));
      chk($sformatf("v%0d_mem_en", v),     32'(bus.mem_en),     32'(vecs[v].e_en));
      chk($sformatf("v%0d_mem_we", v),     32'(bus.mem_we),     32'(vecs[v].e_we));
      chk($sformatf("v%0d_mem_addr", v),   32'(bus.mem_addr),   32'(vecs[v].e_addr));
      chk($sformatf("v%0d_mem_wdata", v),  32'(bus.mem_wdata),  32'(vecs[v].e_wd));
      chk($sformatf("v%0d_cpu_rvalid", v), 32'(bus.cpu_rvalid), 32'(vecs[v].e_crv));
      chk($sformatf("v%0d_spi_rvalid", v), 32'(bus.spi_rvalid), 32'(vecs[v].e_srv));
      if (vecs[v].e_crv)
        chk($sformatf("v%0d_cpu_rdata", v), 32'(bus.cpu_rdata), 32'(vecs[v].e_rdata));
      if (vecs[v].e_srv)
        chk($sformatf("v%0d_spi_rdata", v), 32'(bus.spi_rdata), 32'(vecs[v].e_rdata));
      next_cycle();
    end

    // Continuous contention: SPI forced every 5th cycle.
    for (int k = 0; k < 15; k++) begin
      logic exp_spi;
      exp_spi = ((k % 5) == 4);
      drive(1'b1, 1'b1, 13'(200 + k), 16'(k), 1'b1, 1'b1, 13'(300 + k), 16'(16'h100 + k));
      @(negedge clk);
      chk($sformatf("cont%0d_spi_gnt", k), 32'(bus.spi_gnt), 32'(exp_spi));
      chk($sformatf("cont%0d_cpu_gnt", k), 32'(bus.cpu_gnt), 32'(!exp_spi));
      chk($sformatf("cont%0d_mem_addr", k), 32'(bus.mem_addr),
          exp_spi ? 32'(300 + k) : 32'(200 + k));
      next_cycle();
    end

    drive(1'b0, 1'b0, 13'd0, 16'h0, 1'b0, 1'b0, 13'd0, 16'h0);
    next_cycle();

    // Build wait_cnt to 3, then a CPU read that pushes it to MAX_WAIT.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 13'd400, 16'h0, 1'b1, 1'b1, 13'd500, 16'h0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 13'd10, 16'h0, 1'b1, 1'b1, 13'd500, 16'h0);
    @(negedge clk);
    chk("pre_rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("pre_rst_spi_gnt", 32'(bus.spi_gnt), 32'd0);
    next_cycle();

    reset = 1'b1;
    drive(1'b1, 1'b1, 13'd400, 16'h0, 1'b1, 1'b1, 13'd500, 16'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("midrst%0d_cpu_rvalid", k), 32'(bus.cpu_rvalid), 32'd0);
      chk($sformatf("midrst%0d_cpu_gnt", k),    32'(bus.cpu_gnt),    32'd0);
      chk($sformatf("midrst%0d_spi_gnt", k),    32'(bus.spi_gnt),    32'd0);
      chk($sformatf("midrst%0d_mem_en", k),     32'(bus.mem_en),     32'd0);
      next_cycle();
    end
    reset = 1'b0;

    // wait_cnt restarted from 0: four more refusals before SPI is forced.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post%0d_spi_gnt", k), 32'(bus.spi_gnt), 32'(k == 4));
      chk($sformatf("post%0d_cpu_gnt", k), 32'(bus.cpu_gnt), 32'(k != 4));
      if (k == 0)
        chk("post_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      next_cycle();
    end

    drive(1'b0, 1'b0, 13'd0, 16'h0, 1'b0, 1'b0, 13'd0, 16'h0);
    @(negedge clk);
    chk("idle_mem_en",   32'(bus.mem_en),   32'd0);
    chk("idle_mem_addr", 32'(bus.mem_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
